// File: rtl/trigger_conditioner_if.sv
// Trigger conditioner signal bundle: raw trigger in, qualified trigger and
// statistics out. The slave modport is the conditioner, master is its user.
interface trigger_conditioner_if #(
  parameter int CNT_W = 16
);
  logic             pulse_i;
  logic             polarity_i;
  logic             cnt_clr_i;
  logic             pulse_o;
  logic             busy_o;
  logic [CNT_W-1:0] acc_cnt_o;
  logic [CNT_W-1:0] rej_cnt_o;

  modport slave (
    input  pulse_i,
    input  polarity_i,
    input  cnt_clr_i,
    output pulse_o,
    output busy_o,
    output acc_cnt_o,
    output rej_cnt_o
  );

  modport master (
    output pulse_i,
    output polarity_i,
    output cnt_clr_i,
    input  pulse_o,
    input  busy_o,
    input  acc_cnt_o,
    input  rej_cnt_o
  );
endinterface

// File: rtl/trigger_conditioner.sv
// Trigger conditioner: synchronizes an external trigger, applies polarity,
// accepts only pulses at least FILTER_LEN samples long, emits a single-cycle
// qualified trigger, then ignores the input for HOLDOFF clocks and until the
// input goes inactive again.
// Optional statistics counters are built only when TRIG_CONDITIONER_STATS_EN
// is defined; otherwise the counter outputs read 0 and cnt_clr_i is ignored.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_WAIT_IDLE | input still active (or sync settling); wait for level=0
// S_IDLE      | armed, waiting for the first active sample
// S_QUALIFY   | counting consecutive active samples
// S_HOLDOFF   | dead-time after an accepted pulse, input ignored
module trigger_conditioner #(
  parameter int FILTER_LEN = 3,
  parameter int HOLDOFF    = 16,
  parameter int CNT_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  trigger_conditioner_if.slave bus
);

  typedef enum logic [1:0] {
    S_WAIT_IDLE = 2'd0,
    S_IDLE      = 2'd1,
    S_QUALIFY   = 2'd2,
    S_HOLDOFF   = 2'd3
  } state_t;

  localparam logic [7:0]  FILT_LAST = 8'(FILTER_LEN);
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF - 1);

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [7:0]  filt_q, filt_d;
  logic [15:0] hold_q, hold_d;
  logic        pulse_q, pulse_d;
  logic        level;
  logic        acc_inc;
  logic        rej_inc;

  // Polarity is applied after the synchronizer so a polarity flip looks
  // like any other level change to the FSM.
  assign level = bus.polarity_i ? sync2_q : ~sync2_q;

  // Synchronizer, FSM and timer registers
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_WAIT_IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= '0;
      hold_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      hold_q  <= hold_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state logic: qualification filter, fire, holdoff and re-arm
  always_comb begin
    state_d = state_q;
    sync1_d = bus.pulse_i;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    hold_d  = hold_q;
    pulse_d = 1'b0;
    acc_inc = 1'b0;
    rej_inc = 1'b0;
    case (state_q)
      S_WAIT_IDLE: begin
        if (!level) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (level) begin
          filt_d = 8'd1;
          if (FILTER_LEN == 1) begin
            pulse_d = 1'b1;
            acc_inc = 1'b1;
            hold_d  = '0;
            state_d = S_HOLDOFF;
          end else begin
            state_d = S_QUALIFY;
          end
        end
      end
      S_QUALIFY: begin
        if (level) begin
          filt_d = filt_q + 8'd1;
          if (filt_q + 8'd1 == FILT_LAST) begin
            pulse_d = 1'b1;
            acc_inc = 1'b1;
            hold_d  = '0;
            state_d = S_HOLDOFF;
          end
        end else begin
          rej_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HOLDOFF: begin
        if (hold_q == HOLD_LAST) state_d = S_WAIT_IDLE;
        else                     hold_d  = hold_q + 16'd1;
      end
      default: state_d = S_WAIT_IDLE;
    endcase
  end

  assign bus.pulse_o = pulse_q;
  assign bus.busy_o  = (state_q != S_IDLE);

`ifdef TRIG_CONDITIONER_STATS_EN
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] rej_cnt_q, rej_cnt_d;

  // Statistics counter registers
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      acc_cnt_q <= '0;
      rej_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      rej_cnt_q <= rej_cnt_d;
    end
  end

  // Saturating increments; a clear in the same cycle takes priority
  always_comb begin
    acc_cnt_d = acc_cnt_q;
    rej_cnt_d = rej_cnt_q;
    if (bus.cnt_clr_i) begin
      acc_cnt_d = '0;
      rej_cnt_d = '0;
    end else begin
      if (acc_inc && (acc_cnt_q != '1)) acc_cnt_d = acc_cnt_q + CNT_W'(1);
      if (rej_inc && (rej_cnt_q != '1)) rej_cnt_d = rej_cnt_q + CNT_W'(1);
    end
  end

  assign bus.acc_cnt_o = acc_cnt_q;
  assign bus.rej_cnt_o = rej_cnt_q;
`else
  logic unused_stats;

  assign unused_stats  = acc_inc | rej_inc | bus.cnt_clr_i;
  assign bus.acc_cnt_o = {CNT_W{1'b0}};
  assign bus.rej_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed bench for trigger_conditioner: filter length, latency, holdoff,
// polarity, reset abort, counter clear priority and counter saturation.
module tb_trigger_conditioner;

`ifdef TRIG_CONDITIONER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic resetn;
  int   cyc;
  int   np0, np1;
  int   pcyc0;
  int   n_checks;
  int   n_err;
  int   n0, base;

  trigger_conditioner_if #(.CNT_W(16)) b0 ();
  trigger_conditioner_if #(.CNT_W(4))  b1 ();

  trigger_conditioner #(.FILTER_LEN(3), .HOLDOFF(16), .CNT_W(16)) u0 (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (b0.slave)
  );

  trigger_conditioner #(.FILTER_LEN(3), .HOLDOFF(16), .CNT_W(4)) u1 (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    np0 = 0; np1 = 0; pcyc0 = -1;
  end
  always @(negedge clk) begin
    if (b0.pulse_o === 1'b1) begin
      np0++;
      pcyc0 = cyc;
    end
    if (b1.pulse_o === 1'b1) np1++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  initial begin
    n_checks = 0;
    n_err    = 0;
    resetn = 1'b0;
    b0.pulse_i = 1'b0; b0.polarity_i = 1'b1; b0.cnt_clr_i = 1'b0;
    b1.pulse_i = 1'b0; b1.polarity_i = 1'b1; b1.cnt_clr_i = 1'b0;

    // reset state
    tick(3);
    check("rst_busy",  32'(b0.busy_o), 32'd1);
    check("rst_pulse", 32'(b0.pulse_o), 32'd0);
    check("rst_acc",   32'(b0.acc_cnt_o), 32'd0);
    check("rst_rej",   32'(b0.rej_cnt_o), 32'd0);
    resetn = 1'b1;
    tick(4);
    check("rel_idle", 32'(b0.busy_o), 32'd0);

    // 5-clock active-high pulse: fire after edge 5
    n0 = np0; base = cyc;
    b0.pulse_i = 1'b1;
    tick(5);
    check("t1_pulse_hi", 32'(b0.pulse_o), 32'd1);
    check("t1_cycle", 32'(cyc - base), 32'd5);
    b0.pulse_i = 1'b0;
    tick(1);
    check("t1_single", 32'(b0.pulse_o), 32'd0);
    check("t1_busy_hold", 32'(b0.busy_o), 32'd1);
    tick(30);
    check("t1_npulse", 32'(np0 - n0), 32'd1);
    check("t1_pcyc", 32'(pcyc0 - base), 32'd5);
    check("t1_acc", 32'(b0.acc_cnt_o), st(1));
    check("t1_rej", 32'(b0.rej_cnt_o), st(0));
    check("t1_idle", 32'(b0.busy_o), 32'd0);

    // 2-clock pulse: rejected
    n0 = np0;
    b0.pulse_i = 1'b1;
    tick(2);
    b0.pulse_i = 1'b0;
    tick(2);
    check("t2_qualify", 32'(b0.busy_o), 32'd1);
    tick(1);
    check("t2_idle", 32'(b0.busy_o), 32'd0);
    check("t2_rej", 32'(b0.rej_cnt_o), st(1));
    tick(10);
    check("t2_nopulse", 32'(np0 - n0), 32'd0);
    check("t2_acc", 32'(b0.acc_cnt_o), st(1));

    // holdoff: pulse inside dead-time ignored, later pulse accepted
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(4);
    n0 = np0;
    b0.pulse_i = 1'b1;
    tick(5);
    check("t3_first", 32'(b0.pulse_o), 32'd1);
    b0.pulse_i = 1'b0;
    tick(4);
    b0.pulse_i = 1'b1;
    tick(5);
    b0.pulse_i = 1'b0;
    tick(21);
    check("t3_ignored", 32'(np0 - n0), 32'd1);
    check("t3_rej_ignored", 32'(b0.rej_cnt_o), st(0));
    b0.pulse_i = 1'b1;
    tick(5);
    check("t3_third", 32'(b0.pulse_o), 32'd1);
    b0.pulse_i = 1'b0;
    tick(30);
    check("t3_npulse", 32'(np0 - n0), 32'd2);
    check("t3_acc", 32'(b0.acc_cnt_o), st(2));

    // active-low input held idle-high through reset release
    resetn = 1'b0;
    b0.polarity_i = 1'b0;
    b0.pulse_i = 1'b1;
    tick(2);
    resetn = 1'b1;
    n0 = np0;
    tick(20);
    check("t4_no_spurious", 32'(np0 - n0), 32'd0);
    check("t4_idle", 32'(b0.busy_o), 32'd0);
    base = cyc;
    b0.pulse_i = 1'b0;
    tick(4);
    b0.pulse_i = 1'b1;
    tick(1);
    check("t4_pulse_hi", 32'(b0.pulse_o), 32'd1);
    check("t4_cycle", 32'(cyc - base), 32'd5);
    tick(30);
    check("t4_npulse", 32'(np0 - n0), 32'd1);
    check("t4_acc", 32'(b0.acc_cnt_o), st(1));

    // reset on the 2nd QUALIFY clock aborts
    b0.polarity_i = 1'b1;
    b0.pulse_i = 1'b0;
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(4);
    n0 = np0;
    b0.pulse_i = 1'b1;
    tick(4);
    resetn = 1'b0;
    b0.pulse_i = 1'b0;
    #1;
    check("t5_busy", 32'(b0.busy_o), 32'd1);
    check("t5_pulse", 32'(b0.pulse_o), 32'd0);
    tick(3);
    check("t5_npulse", 32'(np0 - n0), 32'd0);
    check("t5_acc", 32'(b0.acc_cnt_o), 32'd0);
    check("t5_rej", 32'(b0.rej_cnt_o), 32'd0);
    resetn = 1'b1;
    tick(4);
    check("t5_rearm", 32'(b0.busy_o), 32'd0);
    check("t5_no_spurious", 32'(np0 - n0), 32'd0);

    // clear coincident with an accept: clear wins
    b0.pulse_i = 1'b1;
    tick(5);
    b0.pulse_i = 1'b0;
    tick(30);
    check("t6_acc_pre", 32'(b0.acc_cnt_o), st(1));
    b0.pulse_i = 1'b1;
    tick(4);
    b0.cnt_clr_i = 1'b1;
    tick(1);
    b0.cnt_clr_i = 1'b0;
    check("t6_fire", 32'(b0.pulse_o), 32'd1);
    check("t6_clr_wins", 32'(b0.acc_cnt_o), 32'd0);
    b0.pulse_i = 1'b0;
    tick(30);
    check("t6_acc_post", 32'(b0.acc_cnt_o), 32'd0);

    // 4-bit counter saturates at 15
    n0 = np1;
    for (int i = 0; i < 20; i++) begin
      b1.pulse_i = 1'b1;
      tick(5);
      b1.pulse_i = 1'b0;
      tick(25);
      if (i == 14) check("t7_acc_15", 32'(b1.acc_cnt_o), st(15));
    end
    check("t7_npulse", 32'(np1 - n0), 32'd20);
    check("t7_sat", 32'(b1.acc_cnt_o), st(15));
    check("t7_rej", 32'(b1.rej_cnt_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/trigger_conditioner.md
TRIGGER_CONDITIONER -- requirements
Module: trigger_conditioner

Interface
REQ-001 Parameter FILTER_LEN, default 3, consecutive active samples required to accept a pulse; legal range 1..255.
REQ-002 Parameter HOLDOFF, default 16, dead-time in clocks after an accepted pulse; legal range 1..65535.
REQ-003 Parameter CNT_W, default 16, width of the statistics counters.
REQ-004 clk_i  input  1  single system clock; all flops on its rising edge.
REQ-005 resetn_i  input  1  asynchronous, active-low reset.
REQ-006 pulse_i  input  1  raw external trigger, asynchronous to clk_i.
REQ-007 polarity_i  input  1  1 = active-high input, 0 = active-low input; quasi-static.
REQ-008 cnt_clr_i  input  1  synchronous clear of both statistics counters.
REQ-009 pulse_o  output  1  single-cycle qualified trigger, feeds the downstream pulse stretcher.
REQ-010 busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-011 acc_cnt_o  output  CNT_W  number of accepted pulses.
REQ-012 rej_cnt_o  output  CNT_W  number of rejected (too-short) pulses.

Function
REQ-013 pulse_i SHALL pass through a 2-flop synchronizer; polarity is applied after it: level = sync2 when polarity_i=1, else NOT sync2.
REQ-014 FSM states: WAIT_IDLE, IDLE, QUALIFY, HOLDOFF; all transitions registered.
REQ-015 WAIT_IDLE: stay while level=1; go to IDLE on the first clock with level=0.
REQ-016 IDLE: on level=1 load filter count to 1; if FILTER_LEN=1 fire (REQ-018), else go to QUALIFY.
REQ-017 QUALIFY: on level=1 increment filter count; on level=0 increment rej_cnt_o and go to IDLE.
REQ-018 Fire: when filter count reaches FILTER_LEN, assert pulse_o for exactly one clock, increment acc_cnt_o, load holdoff count to 0, and go to HOLDOFF.
REQ-019 Latency: with pulse_i first sampled active at edge 1 and held for at least FILTER_LEN samples, pulse_o SHALL be high in the cycle after edge FILTER_LEN+2.
REQ-020 HOLDOFF: remain for exactly HOLDOFF clocks regardless of level, then go to WAIT_IDLE; input activity here is neither accepted nor counted.
REQ-021 A pulse held active indefinitely SHALL produce exactly one pulse_o; re-arming requires level=0 (WAIT_IDLE).
REQ-022 Counters SHALL saturate at all-ones and never wrap.
REQ-023 If cnt_clr_i and an increment occur in the same cycle, clear wins and the counter reads 0 on the next cycle.
REQ-024 A change of polarity_i mid-operation SHALL be treated as an ordinary level change, with no special handling.
REQ-025 busy_o SHALL be combinational from state (state != IDLE).

Reset
REQ-026 On resetn_i low: sync flops 0, filter and holdoff counts 0, counters 0, pulse_o 0, state WAIT_IDLE (busy_o=1).
REQ-027 Reset asserted mid-QUALIFY or mid-HOLDOFF SHALL abort immediately with no pulse_o and no counter update.
REQ-028 After reset release with an active-low idle-high input, no spurious pulse_o SHALL occur; WAIT_IDLE absorbs the synchronizer settling.

Configuration
REQ-029 Macro TRIG_CONDITIONER_STATS_EN: when defined, acc_cnt_o, rej_cnt_o and cnt_clr_i behave per REQ-017/018/022/023.
REQ-030 When TRIG_CONDITIONER_STATS_EN is undefined, no counter flops exist, acc_cnt_o and rej_cnt_o are tied to 0, cnt_clr_i is ignored, and the FSM and pulse_o are unchanged.

Verification
REQ-031 polarity_i=1, FILTER_LEN=3, pulse_i high for 5 clocks -> one pulse_o, high after edge 5; acc_cnt_o=1; rej_cnt_o=0.
REQ-032 polarity_i=1, FILTER_LEN=3, pulse_i high for 2 clocks -> no pulse_o; rej_cnt_o=1; FSM back in IDLE.
REQ-033 HOLDOFF=16, second 5-clock pulse starting 4 clocks after pulse_o -> ignored; a pulse starting 30 clocks after pulse_o -> accepted; acc_cnt_o=2.
REQ-034 polarity_i=0, pulse_i held high through and after reset release -> no pulse_o; a 4-clock low pulse then yields one pulse_o.
REQ-035 resetn_i asserted on the 2nd QUALIFY clock -> pulse_o stays 0, counters 0, state WAIT_IDLE; CNT_W=4 with 20 accepted pulses -> acc_cnt_o=15; cnt_clr_i coincident with an accept -> acc_cnt_o reads 0.
REQ-036 Build without TRIG_CONDITIONER_STATS_EN, repeat REQ-031 -> identical pulse_o timing; acc_cnt_o and rej_cnt_o constant 0.
